sum_accumulator: RTL and testbench

//   Downstream consumer of the 8-bit adder stage: accepts a stream of adder sums over a

---
 rtl/sum_accumulator.sv | 103 ++++++++++
 tb/tb_sum_accumulator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned adder sums per group and presents the result over valid/ready.
// Define SUM_ACC_SATURATE_EN to clamp the accumulator to all-ones on carry out.
module sum_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 10,
  parameter int COUNT     = 8,
  localparam int CNT_W    = $clog2(COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sum,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [CNT_W-1:0]     out_cnt,
  output logic                 out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state_p0;
  logic [ACC_WIDTH-1:0] acc_p0;
  logic [CNT_W-1:0]     cnt_p0;
  logic                 ovf_p0;
  logic                 vld_p0;

  logic                 accept;
  logic [ACC_WIDTH:0]   sum_c;
  logic [CNT_W-1:0]     cnt_inc;

  // Returns {carry, result}; with saturation the result is clamped when carry is set.
  function automatic logic [ACC_WIDTH:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                input logic [WIDTH-1:0]     s);
    logic [ACC_WIDTH:0] sum;
    sum = {1'b0, a} + (ACC_WIDTH+1)'(s);
`ifdef SUM_ACC_SATURATE_EN
    if (sum[ACC_WIDTH]) sum = {1'b1, {ACC_WIDTH{1'b1}}};
`endif
    return sum;
  endfunction

  assign in_ready = rst_n & (state_p0 != DONE);
  assign accept   = in_valid & in_ready;
  assign sum_c    = acc_add(acc_p0, in_sum);
  assign cnt_inc  = cnt_p0 + CNT_W'(1);

  // Stage p0: group state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      acc_p0   <= '0;
      cnt_p0   <= '0;
      ovf_p0   <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (accept) begin
            acc_p0 <= ACC_WIDTH'(in_sum);
            cnt_p0 <= CNT_W'(1);
            ovf_p0 <= 1'b0;
            if (COUNT == 1) begin
              state_p0 <= DONE;
              vld_p0   <= 1'b1;
            end else begin
              state_p0 <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_p0 <= sum_c[ACC_WIDTH-1:0];
            ovf_p0 <= ovf_p0 | sum_c[ACC_WIDTH];
            cnt_p0 <= cnt_inc;
          end
          if ((accept && (cnt_inc == CNT_W'(COUNT))) || flush) begin
            state_p0 <= DONE;
            vld_p0   <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_p0 <= IDLE;
            vld_p0   <= 1'b0;
            acc_p0   <= '0;
            cnt_p0   <= '0;
            ovf_p0   <= 1'b0;
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  assign out_valid = vld_p0;
  assign out_acc   = acc_p0;
  assign out_cnt   = cnt_p0;
  assign out_ovf   = ovf_p0;

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: directed table, multi-cycle corner sequences and a
// randomized run against a sample-queue reference model.
module tb_sum_accumulator;

  localparam int ACC_MAX = 1023;
`ifdef SUM_ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, flush, out_valid, out_ready, out_ovf;
  logic [7:0] in_sum;
  logic [9:0] out_acc;
  logic [3:0] out_cnt;

  logic       v4, rd4, f4, ov4, r4, ovf4;
  logic [7:0] s4;
  logic [9:0] acc4;
  logic [2:0] cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  sum_accumulator #(.COUNT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rd4), .in_sum(s4),
    .flush(f4), .out_valid(ov4), .out_ready(r4), .out_acc(acc4),
    .out_cnt(cnt4), .out_ovf(ovf4)
  );

  typedef struct {
    int n; int base; int stp; bit fsep; bit fwith; int eacc; int ecnt; int eovf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input bit fl);
    int t = 0;
    in_valid = 1'b1; in_sum = 8'(v); flush = fl;
    while (!in_ready && t < 50) begin step(); t++; end
    if (t >= 50) chk("send_timeout", 0, 1);
    step();
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic result(input string name, input int eacc, input int ecnt, input int eovf);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_acc"}, out_acc, eacc);
    chk({name, "_cnt"}, out_cnt, ecnt);
    chk({name, "_ovf"}, out_ovf, eovf);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk({name, "_drop"}, out_valid, 0);
  endtask

  task automatic reset_mid(input string name);
    #2 rst_n = 1'b0;
    #1;
    chk({name, "_rst_valid"}, out_valid, 0);
    chk({name, "_rst_acc"}, out_acc, 0);
    chk({name, "_rst_cnt"}, out_cnt, 0);
    chk({name, "_rst_ready"}, in_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  function automatic int model_acc(input int total);
    if (SAT) return (total > ACC_MAX) ? ACC_MAX : total;
    return total % (ACC_MAX + 1);
  endfunction

  initial begin
    vec_t tbl[9];
    int   q[$];
    bit   pend;
    int   p_acc, p_cnt, p_ovf, total;
    logic [9:0] h_acc;

    tbl[0] = '{3, 10, 10, 1, 0, 60, 3, 0};
    tbl[1] = '{4, 10, 10, 0, 1, 100, 4, 0};
    tbl[2] = '{8, 255, 0, 0, 0, SAT ? 1023 : 1016, 8, 1};
    tbl[3] = '{8, 1, 0, 0, 0, 8, 8, 0};
    tbl[4] = '{8, 0, 0, 0, 0, 0, 8, 0};
    tbl[5] = '{5, 100, 0, 1, 0, 500, 5, 0};
    tbl[6] = '{8, 128, 0, 0, 0, SAT ? 1023 : 0, 8, 1};
    tbl[7] = '{1, 200, 0, 1, 0, 200, 1, 0};
    tbl[8] = '{8, 100, 10, 0, 0, SAT ? 1023 : 56, 8, 1};

    rst_n = 1'b0; in_valid = 0; in_sum = 0; flush = 0; out_ready = 0;
    v4 = 0; s4 = 0; f4 = 0; r4 = 0;
    step(); step();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_acc", out_acc, 0);
    chk("reset_out_cnt", out_cnt, 0);
    chk("reset_out_ovf", out_ovf, 0);
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("post_reset_in_ready", in_ready, 1);

    // COUNT=4 instance: 15,0,0,15 back-to-back
    v4 = 1; s4 = 15; step(); s4 = 0; step(); step();
    chk("c4_valid_early", ov4, 0);
    s4 = 15; step(); v4 = 0;
    chk("c4_valid", ov4, 1);
    chk("c4_acc", acc4, 30);
    chk("c4_cnt", cnt4, 4);
    chk("c4_ovf", ovf4, 0);
    chk("c4_in_ready", rd4, 0);
    r4 = 1; step(); r4 = 0;
    chk("c4_drop", ov4, 0);

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        send(tbl[i].base + k * tbl[i].stp, tbl[i].fwith && (k == tbl[i].n - 1));
      if (tbl[i].fsep) begin flush = 1; step(); flush = 0; end
      result($sformatf("tbl%0d", i), tbl[i].eacc, tbl[i].ecnt, tbl[i].eovf);
    end

    // Backpressure in DONE while upstream holds 7
    for (int k = 0; k < 8; k++) send(2, 0);
    h_acc = out_acc;
    in_valid = 1; in_sum = 7;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_acc", out_acc, 16);
      chk("hold_acc_stable", out_acc, int'(h_acc));
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1; step(); out_ready = 0;
    chk("hold_drop", out_valid, 0);
    chk("hold_ready_again", in_ready, 1);
    step(); in_valid = 0;
    flush = 1; step(); flush = 0;
    result("hold_next", 7, 1, 0);

    // Reset mid-group, then mid-DONE
    for (int k = 0; k < 5; k++) send(100, 0);
    reset_mid("midgrp");
    for (int k = 0; k < 8; k++) send(1, 0);
    result("after_rst", 8, 8, 0);
    for (int k = 0; k < 8; k++) send(50, 0);
    chk("middone_valid", out_valid, 1);
    reset_mid("middone");

    // Flush in IDLE and bubbles
    flush = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_flush_valid", out_valid, 0);
      chk("idle_flush_ready", in_ready, 1);
    end
    flush = 0;
    for (int k = 0; k < 3; k++) begin
      send(5 + k, 0);
      step(); step();
      chk("bubble_valid", out_valid, 0);
    end
    flush = 1; step(); flush = 0;
    result("bubbles", 18, 3, 0);
    send(9, 1);
    chk("idle_flush_accept", out_valid, 0);
    flush = 1; step(); flush = 0;
    result("idle_flush_sample", 9, 1, 0);

    // Randomized run against the sample-queue model
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_in_ready", in_ready, !pend);
      chk("rnd_out_valid", out_valid, pend);
      if (pend) begin
        chk("rnd_acc", out_acc, p_acc);
        chk("rnd_cnt", out_cnt, p_cnt);
        chk("rnd_ovf", out_ovf, p_ovf);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sum    = 8'($urandom);
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 2) == 0);
      if (pend) begin
        if (out_ready) pend = 0;
      end else begin
        bit had;
        had = (q.size() > 0);
        if (in_valid) q.push_back(int'(in_sum));
        if (q.size() == 8 || (flush && had)) begin
          total = 0;
          foreach (q[j]) total += q[j];
          pend  = 1;
          p_acc = model_acc(total);
          p_cnt = q.size();
          p_ovf = (total > ACC_MAX) ? 1 : 0;
          q.delete();
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
